stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
Sequencing and arbitration controller for the processor's hardware stack. It owns the 8-bit stack pointer and shares one synchronous stack memory between two requesters:
- Port A: the control unit's CALL/RET path, higher priority.
- Port B: the datapath's PUSH/POP path.
Each granted request becomes a memory write (push) or a read-and-capture (pop). Overflow and underflow are guarded with sticky error flags. Sits between the control unit and the stack RAM.

Parameters:
AW, 8, address / stack-pointer width
DW, 8, data width
SP_TOP, 8'hFF, reset SP value; highest stack address; stack empty when SP==SP_TOP
SP_BOTTOM, 8'h80, lowest usable address; must be >=1; stack full when SP==SP_BOTTOM-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
a_req  in  1  port A request; hold until a_ack
a_rw  in  1  port A op: 0=push, 1=pop
a_wdata  in  DW  port A push data
a_ack  out  1  port A one-cycle completion pulse
b_req  in  1  port B request
b_rw  in  1  port B op: 0=push, 1=pop
b_wdata  in  DW  port B push data
b_ack  out  1  port B completion pulse
rdata  out  DW  registered pop result; valid from the ack cycle; held until the next successful pop
mem_addr  out  AW  stack RAM address
mem_wdata  out  DW  stack RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe; RAM returns mem_rdata one cycle later
mem_rdata  in  DW  RAM read data
sp  out  AW  current stack pointer (next free location)
full  out  1  SP==SP_BOTTOM-1
empty  out  1  SP==SP_TOP
err_ovf  out  1  sticky: push attempted while full
err_unf  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
Reset:
- Reset is asynchronous and active-high: clk is the only clock; rst resets asynchronously.
- On rst: state=IDLE, sp=SP_TOP, rdata=0, err_ovf=err_unf=0.
- All strobes low: a_ack, b_ack, mem_we, mem_re=0; mem_addr=mem_wdata=0.
- Strobes are registered, so they drop immediately on rst. No RAM write is issued for an operation cut off mid-flight.

Stack convention: post-decrement push, pre-increment pop.
- Push: mem[SP]<=data, then SP<=SP-1.
- Pop: read mem[SP+1], then SP<=SP+1.

FSM states: IDLE, PUSH, POP_RD, POP_CAP, ACK.
- IDLE: if a_req, grant A; else if b_req, grant B. On grant, latch requester id, rw and wdata.
  - Push while full: set err_ovf, go to ACK. No RAM access, SP unchanged.
  - Pop while empty: set err_unf, go to ACK. No RAM access, SP unchanged.
  - Otherwise go to PUSH (rw=0) or POP_RD (rw=1).
- PUSH: mem_we=1, mem_addr=sp, mem_wdata=latched data; sp<=sp-1; go to ACK.
- POP_RD: mem_re=1, mem_addr=sp+1; sp<=sp+1; go to POP_CAP.
- POP_CAP: rdata<=mem_rdata; go to ACK.
- ACK: the granted port's ack=1 for exactly one cycle; go to IDLE.

Latency (request sampled in IDLE at cycle N):
- Push: ack at N+2.
- Pop: ack at N+3, rdata valid at N+3.
- Rejected op: ack at N+1.

Handshake rules:
- The requester drops req in the cycle after ack. A req still high in IDLE is treated as a new request.
- A request not granted keeps waiting; it is never dropped.
- Requests arriving outside IDLE are ignored until IDLE.
- Fixed priority: A wins a simultaneous request; B waits one full transaction.

Flags and arithmetic:
- full and empty are combinational from sp.
- err_clr together with a new error in the same cycle: set wins.
- SP arithmetic is modulo 2^AW. Wrap cannot occur while SP_BOTTOM>=1 and the guards hold.

Decomposition:
- Shared package stack_pkg holds:
  - state enum encoding;
  - constants RW_PUSH=0 and RW_POP=1;
  - defaults for SP_TOP and SP_BOTTOM.
- One sub-module, stack_arb: a 2-input fixed-priority arbiter producing the grant vector. Its grant is sampled only in IDLE.
- FSM, SP register and error flags stay in stack_ctrl.

Test Plan:
Benches use SP_BOTTOM=8'hFC (depth 4) and a behavioural 1-cycle-latency RAM.
- Reset, then idle 3 cycles -> sp=FF, empty=1, full=0, no strobes, rdata=00.
- B push 8'hA5 -> mem_we with addr FF, data A5; b_ack at N+2; sp=FE. Then B pop -> mem_re with addr FF; b_ack at N+3; rdata=A5; sp=FF, empty=1.
- a_req and b_req rise the same cycle (A push 11, B push 22) -> A acked first with mem[FF]=11; B acked next with mem[FE]=22; sp=FD.
- 4 pushes (01..04) -> full=1, sp=FB. A 5th push -> ack at N+1, no mem_we, err_ovf=1, sp=FB. err_clr -> err_ovf=0.
- Pop on an empty stack -> ack at N+1, no mem_re, err_unf=1, rdata unchanged.
- rst asserted in POP_RD -> outputs cleared asynchronously, sp=FF, state IDLE. Next push writes addr FF.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the hardware stack controller.
package stack_pkg;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PUSH    = 3'd1,
      ST_POP_RD  = 3'd2,
      ST_POP_CAP = 3'd3,
      ST_ACK     = 3'd4
   } state_e;

   // Request opcode encoding on a_rw / b_rw.
   localparam logic RW_PUSH = 1'b0;
   localparam logic RW_POP  = 1'b1;

   // Requester identity latched at grant time.
   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   // Default stack window: empty at the top, full one below the bottom.
   localparam logic [7:0] SP_TOP_DEF    = 8'hFF;
   localparam logic [7:0] SP_BOTTOM_DEF = 8'h80;

endpackage

// File: rtl/stack_arb.sv
// Two-input fixed-priority arbiter: requester A always beats requester B.
module stack_arb (
   input  logic       a_req_i,
   input  logic       b_req_i,
   output logic [1:0] gnt_o
);

   // One-hot grant; bit 0 = A, bit 1 = B, zero when nobody asks.
   always_comb begin
      gnt_o = 2'b00;
      if (a_req_i) begin
         gnt_o = 2'b01;
      end else if (b_req_i) begin
         gnt_o = 2'b10;
      end
   end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller: owns the stack pointer, arbitrates the
// CALL/RET port (A) and the PUSH/POP port (B) onto one synchronous RAM.
//
// Handshake: a requester raises req with rw/wdata stable and holds it
// until its ack pulses for one cycle; it must drop req in the cycle after
// ack, otherwise the controller sees a fresh request once back in IDLE.
// Requests are only looked at in IDLE; a losing request simply waits.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int            AW        = 8,
   parameter int            DW        = 8,
   parameter logic [AW-1:0] SP_TOP    = SP_TOP_DEF,
   parameter logic [AW-1:0] SP_BOTTOM = SP_BOTTOM_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_rw,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   input  logic          b_req,
   input  logic          b_rw,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] sp,
   output logic          full,
   output logic          empty,
   output logic          err_ovf,
   output logic          err_unf,
   input  logic          err_clr,
   output logic [2:0]    dbg_state_o
);

   localparam logic [AW-1:0] SP_FULL = SP_BOTTOM - AW'(1);

   state_e        state_q, state_d;
   logic [AW-1:0] sp_q, sp_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_unf_q, err_unf_d;
   logic          id_q, id_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_re_q, mem_re_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]    gnt;
   logic          gnt_rw;
   logic          ovf_set;
   logic          unf_set;
   logic          full_w;
   logic          empty_w;

   stack_arb u_arb (
      .a_req_i (a_req),
      .b_req_i (b_req),
      .gnt_o   (gnt)
   );

   assign full_w  = (sp_q == SP_FULL);
   assign empty_w = (sp_q == SP_TOP);

   // Next state, SP/rdata/flag updates, and the strobes for the coming cycle.
   // Strobes are derived from the next state so they are registered outputs.
   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      rdata_d   = rdata_q;
      id_d      = id_q;
      wdata_d   = wdata_q;
      gnt_rw    = RW_PUSH;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               id_d    = gnt[1] ? ID_B : ID_A;
               gnt_rw  = gnt[1] ? b_rw : a_rw;
               wdata_d = gnt[1] ? b_wdata : a_wdata;
               if (gnt_rw == RW_PUSH && full_w) begin
                  ovf_set = 1'b1;
                  state_d = ST_ACK;
               end else if (gnt_rw == RW_POP && empty_w) begin
                  unf_set = 1'b1;
                  state_d = ST_ACK;
               end else if (gnt_rw == RW_PUSH) begin
                  state_d = ST_PUSH;
               end else begin
                  state_d = ST_POP_RD;
               end
            end
         end
         ST_PUSH: begin
            sp_d    = sp_q - AW'(1);
            state_d = ST_ACK;
         end
         ST_POP_RD: begin
            sp_d    = sp_q + AW'(1);
            state_d = ST_POP_CAP;
         end
         ST_POP_CAP: begin
            rdata_d = mem_rdata;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new error wins over a simultaneous clear.
      err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
      err_unf_d = unf_set | (err_unf_q & ~err_clr);

      a_ack_d     = (state_d == ST_ACK) && (id_d == ID_A);
      b_ack_d     = (state_d == ST_ACK) && (id_d == ID_B);
      mem_we_d    = (state_d == ST_PUSH);
      mem_re_d    = (state_d == ST_POP_RD);
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (state_d == ST_PUSH) begin
         mem_addr_d  = sp_q;
         mem_wdata_d = wdata_d;
      end else if (state_d == ST_POP_RD) begin
         mem_addr_d  = sp_q + AW'(1);
      end
   end

   // State, datapath and strobe registers; reset drops every strobe at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sp_q        <= SP_TOP;
         rdata_q     <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
         id_q        <= ID_A;
         wdata_q     <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         rdata_q     <= rdata_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
         id_q        <= id_d;
         wdata_q     <= wdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
   assign rdata       = rdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_re      = mem_re_q;
   assign sp          = sp_q;
   assign full        = full_w;
   assign empty       = empty_w;
   assign err_ovf     = err_ovf_q;
   assign err_unf     = err_unf_q;
   assign dbg_state_o = state_q;

endmodule
